// File: rtl/next_receiver.sv
// Serial-to-parallel receiver for the monitor-to-host link.
// Start bit + 40 data bits MSB first, buffered in a small output FIFO.
module next_receiver #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [39:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rx_busy,
  output logic             data_loss,
  output logic [CNT_W-1:0] drop_count,
  input  logic             drop_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [39:0] shift_q, shift_nxt;
  logic [39:0] pkt_word;
  logic        pkt_done;

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    pkt_done    = 1'b0;
    pkt_word    = {shift_q[38:0], sin};
    unique case (state)
      IDLE: begin
        if (sin) begin
          state_nxt   = RECV;
          bit_cnt_nxt = '0;
        end
      end
      RECV: begin
        shift_nxt   = pkt_word;
        bit_cnt_nxt = bit_cnt + 6'd1;
        if (bit_cnt == 6'd39) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift_q <= shift_nxt;
    end
  end

  assign rx_busy = (state == RECV);

  logic [AW:0] wptr, rptr;
  logic [39:0] mem [FIFO_DEPTH];
  logic        empty, full;
  logic        pop, push, drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A pop frees the slot the push lands in, so full only blocks without one.
  assign push  = pkt_done && (!full || pop);
  assign drop  = pkt_done && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= pkt_word;
        wptr              <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  assign out_data  = mem[rptr[AW-1:0]];
  assign out_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_loss  <= 1'b0;
      drop_count <= '0;
    end else begin
      data_loss <= drop;
      unique case (1'b1)
        drop_clear:
          drop_count <= '0;
        drop && (drop_count != {CNT_W{1'b1}}):
          drop_count <= drop_count + CNT_W'(1);
        default:
          drop_count <= drop_count;
      endcase
    end
  end

endmodule

// File: tb/tb_next_receiver.sv
// Randomized scoreboard bench for next_receiver.
// A queue-based packet model predicts FIFO contents, losses and drop count.
module tb_next_receiver;

  localparam int DEPTH   = 2;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sin = 1'b0;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        rx_busy;
  logic        data_loss;
  logic [7:0]  drop_count;
  logic        drop_clear = 1'b0;

  next_receiver #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sin(sin),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rx_busy(rx_busy),
    .data_loss(data_loss),
    .drop_count(drop_count),
    .drop_clear(drop_clear)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Driver-side view of the line, consumed by the model.
  bit          exp_busy  = 1'b0;
  bit          last_bit  = 1'b0;
  logic [39:0] last_word = '0;
  bit          rand_rdy  = 1'b0;

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet queue bounded by DEPTH.
  logic [39:0] mq[$];
  bit          m_loss = 1'b0;
  int          m_cnt  = 0;

  always @(negedge clk) begin
    bit pop, full, do_push;
    if (!rst_n) begin
      chk("rst_valid", 40'(out_valid), 40'd0);
      chk("rst_data", out_data, 40'd0);
      chk("rst_busy", 40'(rx_busy), 40'd0);
      chk("rst_loss", 40'(data_loss), 40'd0);
      chk("rst_count", 40'(drop_count), 40'd0);
      mq.delete();
      m_loss = 1'b0;
      m_cnt  = 0;
    end else begin
      chk("valid", 40'(out_valid), 40'(mq.size() != 0));
      if (mq.size() != 0) chk("data", out_data, mq[0]);
      chk("loss", 40'(data_loss), 40'(m_loss));
      chk("count", 40'(drop_count), 40'(m_cnt));
      chk("busy", 40'(rx_busy), 40'(exp_busy));
      pop     = (mq.size() != 0) && out_ready;
      full    = (mq.size() == DEPTH);
      do_push = 1'b0;
      m_loss  = 1'b0;
      if (last_bit) begin
        if (full && !pop) begin
          m_loss = 1'b1;
          if (m_cnt != CNT_MAX) m_cnt++;
        end else begin
          do_push = 1'b1;
        end
      end
      if (drop_clear) m_cnt = 0;
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(last_word);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [39:0] w, input int nbits,
                      input bit rdy_last, input bit clr_last);
    sin = 1'b1;
    tick();
    exp_busy = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      sin       = w[39-i];
      last_bit  = (i == 39);
      last_word = w;
      if (i == 39 && rdy_last) out_ready = 1'b1;
      drop_clear = (i == 39) && clr_last;
      tick();
    end
    sin        = 1'b0;
    last_bit   = 1'b0;
    drop_clear = 1'b0;
    exp_busy   = 1'b0;
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single packet, then a one-cycle accept.
    send(40'h0700000000, 40, 1'b0, 1'b0);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (2) tick();

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    send(40'hD999999991, 40, 1'b0, 1'b0);
    send(40'hD999999993, 40, 1'b0, 1'b0);
    send(40'hD999999997, 40, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    tick();

    // Overflow: third packet dropped.
    send(40'hAAAAAAAAAA, 40, 1'b0, 1'b0);
    send(40'hBBBBBBBBBB, 40, 1'b0, 1'b0);
    send(40'hCCCCCCCCCC, 40, 1'b0, 1'b0);
    tick();
    drain();

    // Full FIFO with a pop on the completing edge.
    send(40'h1111111111, 40, 1'b0, 1'b0);
    send(40'h2222222222, 40, 1'b0, 1'b0);
    send(40'h3333333333, 40, 1'b1, 1'b0);
    out_ready = 1'b0;
    tick();
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      r = {$urandom, $urandom};
      send(r[39:0], 40, 1'b0, 1'b0);
    end
    drain();

    // Saturate the drop counter, then clear against a drop.
    for (int n = 0; n < CNT_MAX + 6; n++) begin
      r = {$urandom, $urandom};
      send(r[39:0], 40, 1'b0, 1'b0);
    end
    send(40'h5555555555, 40, 1'b0, 1'b1);
    send(40'h6666666666, 40, 1'b0, 1'b0);
    tick();
    drain();

    // Reset mid-packet with a stored packet pending.
    send(40'h7777777777, 40, 1'b0, 1'b0);
    send(40'h8888888888, 20, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    send(40'h0F00000000, 40, 1'b0, 1'b0);
    tick();
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
